// File: rtl/minisys_pkg.sv
// Shared definitions for the pipeline control slice: hazard FSM states,
// forwarding source codes and the hard-wired zero register.
package minisys_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LDSTALL  = 2'd1,
        CTISTALL = 2'd2,
        HOLD     = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EX      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_WB      = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // $0 is hard-wired, so it can never carry a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Compare-operand forwarding selector for one source register; purely
// combinational, priority EX > MEM > WB > register file.
module hazard_fwd_sel
    import minisys_pkg::*;
(
    input  logic [4:0] src_reg,
    input  logic [4:0] EX_rd,
    input  logic       EX_wreg,
    input  logic       EX_memread,
    input  logic [4:0] MEM_rd,
    input  logic       MEM_wreg,
    input  logic       MEM_memread,
    input  logic [4:0] WB_rd,
    input  logic       WB_wreg,
    output logic [1:0] fwd_sel
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // A load in EX has no data yet; a load in MEM always writes its rd.
    assign ex_hit  = EX_wreg && !EX_memread && reg_match(src_reg, EX_rd);
    assign mem_hit = (MEM_wreg || MEM_memread) && reg_match(src_reg, MEM_rd);
    assign wb_hit  = WB_wreg && reg_match(src_reg, WB_rd);

    always_comb begin
        fwd_sel = FWD_REGFILE;
        if (ex_hit) begin
            fwd_sel = FWD_EX;
        end else if (mem_hit) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard controller: load-use and CTI-compare stalls, external
// hold, IF flush on taken control transfers, forwarding selects and counters.
module pipe_hazard_ctrl
    import minisys_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_use_rs,
    input  logic        ID_use_rt,
    input  logic        ID_is_cti,
    input  logic [4:0]  EX_rd,
    input  logic [4:0]  MEM_rd,
    input  logic [4:0]  WB_rd,
    input  logic        EX_wreg,
    input  logic        MEM_wreg,
    input  logic        WB_wreg,
    input  logic        EX_memread,
    input  logic        MEM_memread,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        ID_jump,
    input  logic        ext_stall,
    output logic        IF_WPC,
    output logic        IF_ID_write,
    output logic        ID_EX_bubble,
    output logic        IF_flush,
    output logic [1:0]  FWD_AluCsrc,
    output logic [1:0]  FWD_AluDsrc,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    hz_state_t  state;
    logic [1:0] sel_c;
    logic [1:0] sel_d;
    logic       rs_hit_ex;
    logic       rt_hit_ex;
    logic       ld_haz;
    logic       cti_haz;
    logic       hazard;
    logic       cti_taken;
    logic       in_stall;

    hazard_fwd_sel u_fwd_rs (
        .src_reg     (ID_rs),
        .EX_rd       (EX_rd),
        .EX_wreg     (EX_wreg),
        .EX_memread  (EX_memread),
        .MEM_rd      (MEM_rd),
        .MEM_wreg    (MEM_wreg),
        .MEM_memread (MEM_memread),
        .WB_rd       (WB_rd),
        .WB_wreg     (WB_wreg),
        .fwd_sel     (sel_c)
    );

    hazard_fwd_sel u_fwd_rt (
        .src_reg     (ID_rt),
        .EX_rd       (EX_rd),
        .EX_wreg     (EX_wreg),
        .EX_memread  (EX_memread),
        .MEM_rd      (MEM_rd),
        .MEM_wreg    (MEM_wreg),
        .MEM_memread (MEM_memread),
        .WB_rd       (WB_rd),
        .WB_wreg     (WB_wreg),
        .fwd_sel     (sel_d)
    );

    assign rs_hit_ex = ID_use_rs && reg_match(ID_rs, EX_rd);
    assign rt_hit_ex = ID_use_rt && reg_match(ID_rt, EX_rd);
    assign ld_haz    = (rs_hit_ex || rt_hit_ex) && EX_memread;
    assign cti_haz   = ID_is_cti && (rs_hit_ex || rt_hit_ex) && EX_wreg && !EX_memread;
    assign hazard    = ld_haz || cti_haz;
    assign cti_taken = Branch || nBranch || ID_jump;
    assign in_stall  = (state == LDSTALL) || (state == CTISTALL);

    assign FWD_AluCsrc = reset ? FWD_REGFILE : sel_c;
    assign FWD_AluDsrc = reset ? FWD_REGFILE : sel_d;

    // ext_stall and reset act in the same cycle, ahead of the registered state.
    always_comb begin
        IF_WPC       = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b0;
        IF_flush     = 1'b0;
        if (reset) begin
            ID_EX_bubble = 1'b1;
        end else if (!ext_stall) begin
            unique case (state)
                RUN: begin
                    IF_WPC      = 1'b1;
                    IF_ID_write = 1'b1;
                    IF_flush    = !hazard && cti_taken;
                end
                LDSTALL, CTISTALL: begin
                    ID_EX_bubble = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else if (ext_stall) begin
            state <= HOLD;
        end else begin
            unique case (state)
                RUN: begin
                    if (ld_haz) begin
                        state <= LDSTALL;
                    end else if (cti_haz) begin
                        state <= CTISTALL;
                    end else begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (in_stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (IF_flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule
